alu_iter: RTL

- Execute-stage ALU, directly downstream of the ALU control stage. Consumes its 4-bit ALU control code plus two operands.
- Single-cycle ops (AND, OR, ADD, SUB, SLT) complete in 1 cycle.
- New MUL op is computed by an iterative shift-add datapath over WIDTH cycles.
- Start/busy/done handshake lets the multi-cycle CPU control FSM stall on MUL.

---
 rtl/alu_iter_pkg.sv | 36 +++
 rtl/alu_mul_iter.sv | 47 ++++
 rtl/alu_iter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_iter_pkg.sv
// Shared ALU control codes, handshake FSM encoding and flag bundle for the execute-stage ALU.
package alu_iter_pkg;

    localparam int unsigned CTRL_W = 4;

    typedef enum logic [CTRL_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_MUL = 4'b1000
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    typedef struct packed {
        logic zero;
        logic overflow;
        logic illegal;
    } alu_flags_t;

    function automatic logic is_legal(input logic [CTRL_W-1:0] code);
        logic legal;
        legal = 1'b0;
        case (code)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_MUL: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: start loads operands, each step retires one multiplier bit.
module alu_mul_iter
    import alu_iter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum_c,
    output logic             done_c
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] count;

    // Accumulator value after the current step; on the last step this is the product.
    assign sum_c  = acc + (mplier[0] ? mcand : '0);
    assign done_c = step && (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
        end else if (step) begin
            acc    <= sum_c;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Execute-stage ALU: single-cycle logic/arith ops plus a multi-cycle MUL behind a start/busy/done handshake.
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [CTRL_W-1:0] ALUCtrl_i,
    input  logic [WIDTH-1:0]  src1_i,
    input  logic [WIDTH-1:0]  src2_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [WIDTH-1:0]  result_o,
    output logic              zero_o,
    output logic              overflow_o,
    output logic              illegal_o
);

    state_e           state;
    state_e           state_next;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_next;
    alu_flags_t       flags;
    alu_flags_t       flags_next;
    logic             done;
    logic             done_next;
    logic             busy;
    logic             busy_next;

    alu_op_e          op;
    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             add_ovf;
    logic             slt;
    logic [WIDTH-1:0] alu_c;
    logic             ovf_c;

    logic             mul_start;
    logic             mul_step;
    logic [WIDTH-1:0] mul_sum_c;
    logic             mul_done_c;

    assign op = alu_op_e'(ALUCtrl_i);

    // Shared adder: SUB is A + ~B + 1, overflow judged on the effective B operand.
    assign sub     = (op == ALU_SUB);
    assign b_eff   = sub ? ~src2_i : src2_i;
    assign sum     = src1_i + b_eff + {{(WIDTH-1){1'b0}}, sub};
    assign add_ovf = (src1_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
    assign slt     = ($signed(src1_i) < $signed(src2_i));

    always_comb begin
        alu_c = '0;
        ovf_c = 1'b0;
        case (op)
            ALU_AND: alu_c = src1_i & src2_i;
            ALU_OR:  alu_c = src1_i | src2_i;
            ALU_ADD: begin
                alu_c = sum;
                ovf_c = add_ovf;
            end
            ALU_SUB: begin
                alu_c = sum;
                ovf_c = add_ovf;
            end
            ALU_SLT: alu_c = {{(WIDTH-1){1'b0}}, slt};
            default: alu_c = '0;
        endcase
    end

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk_i),
        .rst    (rst_i),
        .start  (mul_start),
        .step   (mul_step),
        .a      (src1_i),
        .b      (src2_i),
        .sum_c  (mul_sum_c),
        .done_c (mul_done_c)
    );

    // Handshake FSM: busy is raised on the first iteration edge and dropped with the completing one.
    always_comb begin
        state_next  = state;
        result_next = result;
        flags_next  = flags;
        done_next   = 1'b0;
        busy_next   = 1'b0;
        mul_start   = 1'b0;
        mul_step    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    if (op == ALU_MUL) begin
                        mul_start  = 1'b1;
                        state_next = ST_MUL;
                    end else begin
                        result_next         = alu_c;
                        flags_next.zero     = (alu_c == '0);
                        flags_next.overflow = ovf_c;
                        flags_next.illegal  = !is_legal(ALUCtrl_i);
                        done_next           = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                mul_step  = 1'b1;
                busy_next = 1'b1;
                if (mul_done_c) begin
                    result_next         = mul_sum_c;
                    flags_next.zero     = (mul_sum_c == '0);
                    flags_next.overflow = 1'b0;
                    flags_next.illegal  = 1'b0;
                    done_next           = 1'b1;
                    busy_next           = 1'b0;
                    state_next          = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= ST_IDLE;
            result         <= '0;
            flags.zero     <= 1'b1;
            flags.overflow <= 1'b0;
            flags.illegal  <= 1'b0;
            done           <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state  <= state_next;
            result <= result_next;
            flags  <= flags_next;
            done   <= done_next;
            busy   <= busy_next;
        end
    end

    assign busy_o     = busy;
    assign done_o     = done;
    assign result_o   = result;
    assign zero_o     = flags.zero;
    assign overflow_o = flags.overflow;
    assign illegal_o  = flags.illegal;

endmodule
